// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the accumulator-CPU control sequencer.
// Holds the stage encoding, opcode values, and the control-word bit masks.
// The CPU datapath muxes use the same control-word bit map.
// Control word bits:
//   j0 co1 ce2 oi3 bi4 su5 eo6 ao7 ai8 ii9 io10 ro11 ri12 mi13 hlt14
package control_sequencer_pkg;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned CTRL_W   = 15;
    localparam int unsigned STAGE_W  = 3;

    typedef enum logic [STAGE_W-1:0] {
        ST_INIT = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_T5   = 3'd5
    } stage_t;

    localparam logic [OPCODE_W-1:0] OP_NOP = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_LDA = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_STA = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_LDI = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_JMP = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_JC  = 4'b0111;
    localparam logic [OPCODE_W-1:0] OP_JZ  = 4'b1000;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'b1111;

    localparam logic [CTRL_W-1:0] CB_J   = 15'h0001;
    localparam logic [CTRL_W-1:0] CB_CO  = 15'h0002;
    localparam logic [CTRL_W-1:0] CB_CE  = 15'h0004;
    localparam logic [CTRL_W-1:0] CB_OI  = 15'h0008;
    localparam logic [CTRL_W-1:0] CB_BI  = 15'h0010;
    localparam logic [CTRL_W-1:0] CB_SU  = 15'h0020;
    localparam logic [CTRL_W-1:0] CB_EO  = 15'h0040;
    localparam logic [CTRL_W-1:0] CB_AO  = 15'h0080;
    localparam logic [CTRL_W-1:0] CB_AI  = 15'h0100;
    localparam logic [CTRL_W-1:0] CB_II  = 15'h0200;
    localparam logic [CTRL_W-1:0] CB_IO  = 15'h0400;
    localparam logic [CTRL_W-1:0] CB_RO  = 15'h0800;
    localparam logic [CTRL_W-1:0] CB_RI  = 15'h1000;
    localparam logic [CTRL_W-1:0] CB_MI  = 15'h2000;
    localparam logic [CTRL_W-1:0] CB_HLT = 15'h4000;

    // ALU result written back to A: the stage after which C/Z are latched
    localparam logic [CTRL_W-1:0] CB_FLAG_LOAD = CB_EO | CB_AI;

endpackage

// File: rtl/control_sequencer_rom.sv
// Microcode ROM: combinational map from the stage being entered, the opcode
// in effect for that stage, and the latched flags to the control word to be
// registered for that stage plus a flag marking the instruction's last stage.
// Ports:
//   stage   in  stage about to be entered
//   op      in  opcode governing that stage
//   c, z    in  latched carry / zero flags
//   ctrl    out control word for that stage
//   last    out 1 if that stage ends the instruction
module control_sequencer_rom
    import control_sequencer_pkg::*;
(
    input  stage_t              stage,
    input  logic [OPCODE_W-1:0] op,
    input  logic                c,
    input  logic                z,
    output logic [CTRL_W-1:0]   ctrl,
    output logic                last
);

    always_comb begin
        ctrl = '0;
        last = 1'b0;
        case (stage)
            ST_T1: ctrl = CB_MI | CB_CO;
            ST_T2: ctrl = CB_RO | CB_II | CB_CE;
            ST_T3: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl = CB_IO | CB_MI;
                    OP_LDI: begin ctrl = CB_IO | CB_AI; last = 1'b1; end
                    OP_JMP: begin ctrl = CB_IO | CB_J;  last = 1'b1; end
                    OP_OUT: begin ctrl = CB_AO | CB_OI; last = 1'b1; end
                    OP_JC: begin
                        ctrl = c ? (CB_IO | CB_J) : '0;
                        last = 1'b1;
                    end
                    OP_JZ: begin
                        ctrl = z ? (CB_IO | CB_J) : '0;
                        last = 1'b1;
                    end
                    OP_HLT: ctrl = CB_HLT;
                    default: last = 1'b1;
                endcase
            end
            ST_T4: begin
                case (op)
                    OP_LDA:         begin ctrl = CB_RO | CB_AI; last = 1'b1; end
                    OP_ADD, OP_SUB: ctrl = CB_RO | CB_BI;
                    OP_STA:         begin ctrl = CB_RI | CB_AO; last = 1'b1; end
                    default:        last = 1'b1;
                endcase
            end
            ST_T5: begin
                last = 1'b1;
                case (op)
                    OP_ADD:  ctrl = CB_EO | CB_AI;
                    OP_SUB:  ctrl = CB_EO | CB_AI | CB_SU;
                    default: ctrl = '0;
                endcase
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control unit for the 8-bit accumulator CPU.
// Steps INIT,T1..T5, decodes the opcode through the microcode ROM and drives
// the registered control word. Also keeps the latched ALU flags, run/step
// gating and the sticky halt. All state changes on the falling clock edge.
// Ports:
//   clk         system clock (state updates on negedge)
//   rst         asynchronous active-high reset
//   run         free-run enable
//   step        level-sampled single-step request when run=0
//   opcode      IR[7:4]
//   carry_in    ALU carry out
//   zero_in     ALU result is zero
//   ctrl        registered control word
//   stage       current stage (INIT=0, T1..T5=1..5)
//   halted      sticky halt status
//   instr_done  high during the last stage of each instruction
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int unsigned OPCODE_WIDTH = 4,
    parameter int unsigned CTRL_WIDTH   = 15,
    parameter int unsigned STAGE_WIDTH  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic                    step,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    carry_in,
    input  logic                    zero_in,
    output logic [CTRL_WIDTH-1:0]   ctrl,
    output logic [STAGE_WIDTH-1:0]  stage,
    output logic                    halted,
    output logic                    instr_done
);

    stage_t              stage_q, stage_d, target;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d, rom_ctrl;
    logic                done_q, done_d, rom_last;
    logic                c_q, c_d, z_q, z_d;
    logic                halted_q, halted_d;
    logic [OPCODE_W-1:0] op_q, op_d, rom_op;
    logic                advance;

    assign advance = (run | step) & ~halted_q;

    // Stage that the next advance would enter.
    always_comb begin
        target = ST_T1;
        case (stage_q)
            ST_INIT: target = ST_T1;
            ST_T1:   target = ST_T2;
            ST_T2:   target = ST_T3;
            ST_T3:   target = done_q ? ST_T1 : ST_T4;
            ST_T4:   target = done_q ? ST_T1 : ST_T5;
            ST_T5:   target = ST_T1;
            default: target = ST_T1;
        endcase
    end

    // The opcode is captured at the edge entering T3, so that stage must
    // decode the live input rather than the not-yet-loaded op register.
    assign rom_op = (target == ST_T3) ? opcode : op_q;

    control_sequencer_rom u_rom (
        .stage (target),
        .op    (rom_op),
        .c     (c_q),
        .z     (z_q),
        .ctrl  (rom_ctrl),
        .last  (rom_last)
    );

    always_comb begin
        stage_d  = stage_q;
        ctrl_d   = ctrl_q;
        done_d   = done_q;
        c_d      = c_q;
        z_d      = z_q;
        halted_d = halted_q;
        op_d     = op_q;
        if (advance) begin
            if ((ctrl_q & CB_HLT) != '0) begin
                // Freeze in the HLT stage with its control word still asserted.
                halted_d = 1'b1;
            end else begin
                stage_d = target;
                ctrl_d  = rom_ctrl;
                done_d  = rom_last;
                if (target == ST_T3) begin
                    op_d = opcode;
                end
                if ((ctrl_q & CB_FLAG_LOAD) == CB_FLAG_LOAD) begin
                    c_d = carry_in;
                    z_d = zero_in;
                end
            end
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            stage_q  <= ST_INIT;
            ctrl_q   <= '0;
            done_q   <= 1'b0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            halted_q <= 1'b0;
            op_q     <= '0;
        end else begin
            stage_q  <= stage_d;
            ctrl_q   <= ctrl_d;
            done_q   <= done_d;
            c_q      <= c_d;
            z_q      <= z_d;
            halted_q <= halted_d;
            op_q     <= op_d;
        end
    end

    assign ctrl       = ctrl_q;
    assign stage      = stage_q;
    assign halted     = halted_q;
    assign instr_done = done_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer.
module tb_control_sequencer;

    localparam logic [3:0] NOP = 4'b0000, LDA = 4'b0001, ADD = 4'b0010, SUB = 4'b0011;
    localparam logic [3:0] STA = 4'b0100, LDI = 4'b0101, JMP = 4'b0110, JC  = 4'b0111;
    localparam logic [3:0] JZ  = 4'b1000, OUT = 4'b1110, HLT = 4'b1111, UND = 4'b1010;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [3:0]  opcode = 4'b0000;
    logic        carry_in = 1'b0;
    logic        zero_in = 1'b0;
    logic [14:0] ctrl;
    logic [2:0]  stage;
    logic        halted;
    logic        instr_done;

    int total = 0;
    int bad   = 0;

    control_sequencer #(
        .OPCODE_WIDTH (4),
        .CTRL_WIDTH   (15),
        .STAGE_WIDTH  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .step       (step),
        .opcode     (opcode),
        .carry_in   (carry_in),
        .zero_in    (zero_in),
        .ctrl       (ctrl),
        .stage      (stage),
        .halted     (halted),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [14:0] got, input logic [14:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%04h exp=0x%04h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        run = 1'b0; step = 1'b0;
        do_reset();
        chk("reset stage", 15'(stage), 15'd0);
        chk("reset ctrl", ctrl, 15'h0000);
        chk("reset halted", 15'(halted), 15'd0);
        chk("reset done", 15'(instr_done), 15'd0);
        tick();
        chk("idle stage held", 15'(stage), 15'd0);
    endtask

    task automatic test_add();
        logic [14:0] exp_ctrl [6];
        logic [2:0]  exp_stage [6];
        exp_ctrl  = '{15'h2002, 15'h0A04, 15'h2400, 15'h0810, 15'h0140, 15'h2002};
        exp_stage = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1};
        do_reset();
        opcode = ADD; run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("add ctrl[%0d]", i), ctrl, exp_ctrl[i]);
            chk($sformatf("add stage[%0d]", i), 15'(stage), 15'(exp_stage[i]));
            chk($sformatf("add done[%0d]", i), 15'(instr_done), (i == 4) ? 15'd1 : 15'd0);
        end
        run = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        opcode = ADD; run = 1'b1;
        repeat (4) tick();
        chk("mid pre ctrl", ctrl, 15'h0810);
        rst = 1'b1;
        #1;
        chk("mid rst stage", 15'(stage), 15'd0);
        chk("mid rst ctrl", ctrl, 15'h0000);
        @(posedge clk);
        rst = 1'b0;
        tick();
        chk("mid rel ctrl1", ctrl, 15'h2002);
        tick();
        chk("mid rel ctrl2", ctrl, 15'h0A04);
        run = 1'b0;
    endtask

    task automatic test_flags_jumps();
        do_reset();
        opcode = SUB; carry_in = 1'b1; zero_in = 1'b0; run = 1'b1;
        repeat (5) tick();
        chk("sub t5 ctrl", ctrl, 15'h0160);
        opcode = JC;
        tick();                       // leaves SUB T5: C=1, Z=0
        carry_in = 1'b0; zero_in = 1'b1;
        tick(); tick();
        chk("jc taken ctrl", ctrl, 15'h0401);
        chk("jc taken done", 15'(instr_done), 15'd1);
        chk("jz flag not set", 15'(stage), 15'd3);
        opcode = ADD;
        tick();
        chk("jc then t1", 15'(stage), 15'd1);
        repeat (4) tick();
        chk("add t5 ctrl", ctrl, 15'h0140);
        opcode = JC;
        tick();                       // leaves ADD T5: C=0, Z=1
        carry_in = 1'b1; zero_in = 1'b0;
        tick(); tick();
        chk("jc not taken ctrl", ctrl, 15'h0000);
        chk("jc not taken done", 15'(instr_done), 15'd1);
        opcode = JZ;
        tick();
        chk("after jc stage", 15'(stage), 15'd1);
        chk("after jc ctrl", ctrl, 15'h2002);
        tick(); tick();
        chk("jz taken ctrl", ctrl, 15'h0401);
        run = 1'b0; carry_in = 1'b0; zero_in = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        opcode = HLT; run = 1'b1;
        repeat (3) tick();
        chk("hlt t3 ctrl", ctrl, 15'h4000);
        chk("hlt t3 halted", 15'(halted), 15'd0);
        tick();
        chk("hlt halted", 15'(halted), 15'd1);
        chk("hlt stage", 15'(stage), 15'd3);
        step = 1'b1; opcode = NOP;
        repeat (20) tick();
        chk("hlt held stage", 15'(stage), 15'd3);
        chk("hlt held ctrl", ctrl, 15'h4000);
        chk("hlt held halted", 15'(halted), 15'd1);
        run = 1'b0; step = 1'b0;
        do_reset();
        chk("hlt cleared", 15'(halted), 15'd0);
        chk("hlt rst stage", 15'(stage), 15'd0);
    endtask

    task automatic test_step();
        do_reset();
        run = 1'b0; opcode = LDA;
        for (int i = 1; i <= 3; i++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            chk($sformatf("step stage[%0d]", i), 15'(stage), 15'(i));
            tick();
            chk($sformatf("step hold[%0d]", i), 15'(stage), 15'(i));
        end
        tick(); tick();
        chk("step held ctrl", ctrl, 15'h2400);
        step = 1'b1;
        tick();
        chk("step lda t4", ctrl, 15'h0900);
        tick();
        step = 1'b0;
        chk("step lda end", 15'(stage), 15'd1);
    endtask

    task automatic test_undefined();
        do_reset();
        opcode = UND; run = 1'b1;
        repeat (3) tick();
        chk("undef ctrl", ctrl, 15'h0000);
        chk("undef done", 15'(instr_done), 15'd1);
        chk("undef stage", 15'(stage), 15'd3);
        tick();
        chk("undef next stage", 15'(stage), 15'd1);
        chk("undef next ctrl", ctrl, 15'h2002);
        chk("undef next done", 15'(instr_done), 15'd0);
        run = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops  [6];
        logic [14:0] w3   [6];
        logic [14:0] w4   [6];
        int          len  [6];
        ops = '{LDA, STA, LDI, JMP, OUT, NOP};
        w3  = '{15'h2400, 15'h2400, 15'h0500, 15'h0401, 15'h0088, 15'h0000};
        w4  = '{15'h0900, 15'h1080, 15'h0000, 15'h0000, 15'h0000, 15'h0000};
        len = '{2, 2, 1, 1, 1, 1};
        do_reset();
        run = 1'b1;
        for (int k = 0; k < 6; k++) begin
            opcode = ops[k];
            tick();
            chk($sformatf("b2b t1 op%0d", k), ctrl, 15'h2002);
            tick();
            chk($sformatf("b2b t2 op%0d", k), ctrl, 15'h0A04);
            tick();
            opcode = NOP;             // op register must hold the sampled opcode
            chk($sformatf("b2b t3 op%0d", k), ctrl, w3[k]);
            chk($sformatf("b2b t3 done op%0d", k), 15'(instr_done), (len[k] == 1) ? 15'd1 : 15'd0);
            if (len[k] == 2) begin
                tick();
                chk($sformatf("b2b t4 op%0d", k), ctrl, w4[k]);
                chk($sformatf("b2b t4 done op%0d", k), 15'(instr_done), 15'd1);
            end
        end
        tick();
        chk("b2b final stage", 15'(stage), 15'd1);
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_reset_mid();
        test_flags_jumps();
        test_halt();
        test_step();
        test_undefined();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
